// File: rtl/ins_cache_nway_if.sv
// Command, fill and response bundle for ins_cache_nway.
// slave = cache side, master = requester / next level.
interface ins_cache_nway_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_LOG2 = 6
);
  logic [3:0]                  cmd;
  logic                        cmd_valid;
  logic [ADDR_W-1:0]           addr;
  logic                        ready;
  logic                        fill_req;
  logic [ADDR_W-LINE_LOG2-1:0] fill_addr;
  logic                        fill_ack;
  logic                        rsp_valid;
  logic                        rsp_hit;
  logic [31:0]                 hit_cnt;
  logic [31:0]                 miss_cnt;
  logic [31:0]                 read_cnt;

  modport slave (
    input  cmd, cmd_valid, addr, fill_ack,
    output ready, fill_req, fill_addr,
    output rsp_valid, rsp_hit,
    output hit_cnt, miss_cnt, read_cnt
  );

  modport master (
    output cmd, cmd_valid, addr, fill_ack,
    input  ready, fill_req, fill_addr,
    input  rsp_valid, rsp_hit,
    input  hit_cnt, miss_cnt, read_cnt
  );
endinterface

// File: rtl/ins_cache_nway.sv
// N-way set-associative instruction cache tag controller with LRU ages.
// Define ICACHE_STATS_EN to build the hit/miss/read counters.
module ins_cache_nway #(
  parameter int WAYS      = 2,
  parameter int SETS_LOG2 = 14,
  parameter int LINE_LOG2 = 6,
  parameter int ADDR_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  ins_cache_nway_if.slave  bus
);
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int LA_W  = ADDR_W - LINE_LOG2;
  localparam int TAG_W = ADDR_W - SETS_LOG2 - LINE_LOG2;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [3:0] CMD_CLEAR = 4'd8;
  localparam logic [3:0] CMD_INV   = 4'd3;
  localparam logic [3:0] CMD_FETCH = 4'd2;
  localparam logic [3:0] CMD_PRINT = 4'd9;

  typedef enum logic [2:0] {
    SWEEP, IDLE, LOOKUP, FILL, INSTALL
  } state_e;

  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

  logic [WAYS-1:0]             valid_mem [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];
  ages_t                       age_mem   [SETS];

  state_e                 state_q, state_d;
  logic [SETS_LOG2-1:0]   sweep_q, sweep_d;
  logic [LA_W-1:0]        addr_q, addr_d;
  logic                   fill_req_q, fill_req_d;
  logic [LA_W-1:0]        fill_addr_q, fill_addr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_hit_q, rsp_hit_d;

  logic [SETS_LOG2-1:0]   rd_set, wr_set;
  logic [TAG_W-1:0]       rd_tag;
  logic [WAYS-1:0]        rd_valid;
  logic [WAYS-1:0][TAG_W-1:0] rd_tags;
  ages_t                  rd_age;
  logic [WAYS-1:0]        hit_vec;
  logic                   hit_any;
  logic [AGE_W-1:0]       hit_way, victim;

  logic                   valid_we, tag_we, age_we;
  logic [WAYS-1:0]        valid_row;
  ages_t                  age_row;
  logic [AGE_W-1:0]       tag_way;

  logic [LINE_LOG2-1:0]   unused_addr;
  assign unused_addr = bus.addr[LINE_LOG2-1:0];

  // The accessed way becomes youngest; ways younger than it age by one.
  function automatic ages_t touch(input ages_t a,
                                  input logic [AGE_W-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == w)   r[i] = '0;
      else if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    end
    return r;
  endfunction

  // IDLE looks up the live address (invalidate), others the captured one.
  always_comb begin
    if (state_q == IDLE) begin
      rd_set = bus.addr[SETS_LOG2+LINE_LOG2-1:LINE_LOG2];
      rd_tag = bus.addr[ADDR_W-1:SETS_LOG2+LINE_LOG2];
    end else begin
      rd_set = addr_q[SETS_LOG2-1:0];
      rd_tag = addr_q[LA_W-1:SETS_LOG2];
    end
  end

  assign rd_valid = valid_mem[rd_set];
  assign rd_tags  = tag_mem[rd_set];
  assign rd_age   = age_mem[rd_set];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    victim  = '0;
    for (int i = 0; i < WAYS; i++)
      hit_vec[i] = rd_valid[i] && (rd_tags[i] == rd_tag);
    for (int i = WAYS - 1; i >= 0; i--)
      if (hit_vec[i]) hit_way = AGE_W'(i);
    for (int i = 1; i < WAYS; i++)
      if (rd_age[i] > rd_age[victim]) victim = AGE_W'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!rd_valid[i]) victim = AGE_W'(i);
  end

  assign hit_any = |hit_vec;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    addr_d      = addr_q;
    fill_req_d  = fill_req_q;
    fill_addr_d = fill_addr_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    wr_set      = rd_set;
    valid_we    = 1'b0;
    valid_row   = rd_valid;
    tag_we      = 1'b0;
    tag_way     = victim;
    age_we      = 1'b0;
    age_row     = rd_age;
    unique case (state_q)
      SWEEP: begin
        wr_set    = sweep_q;
        valid_we  = 1'b1;
        valid_row = '0;
        age_we    = 1'b1;
        for (int i = 0; i < WAYS; i++)
          age_row[i] = AGE_W'(i);
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.addr[ADDR_W-1:LINE_LOG2];
          unique case (1'b1)
            (bus.cmd == CMD_FETCH): state_d = LOOKUP;
            (bus.cmd == CMD_CLEAR): begin
              state_d = SWEEP;
              sweep_d = '0;
            end
            (bus.cmd == CMD_INV): begin
              if (hit_any) begin
                valid_we           = 1'b1;
                valid_row[hit_way] = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          age_we      = 1'b1;
          age_row     = touch(rd_age, hit_way);
          state_d     = IDLE;
        end else begin
          fill_req_d  = 1'b1;
          fill_addr_d = addr_q;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (bus.fill_ack) begin
          fill_req_d = 1'b0;
          state_d    = INSTALL;
        end
      end
      INSTALL: begin
        tag_we            = 1'b1;
        valid_we          = 1'b1;
        valid_row[victim] = 1'b1;
        age_we            = 1'b1;
        age_row           = touch(rd_age, victim);
        rsp_valid_d       = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_q     <= '0;
      addr_q      <= '0;
      fill_req_q  <= 1'b0;
      fill_addr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      addr_q      <= addr_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (valid_we) valid_mem[wr_set] <= valid_row;
      if (tag_we)   tag_mem[wr_set][tag_way] <= rd_tag;
      if (age_we)   age_mem[wr_set] <= age_row;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.fill_req  = fill_req_q;
  assign bus.fill_addr = fill_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;

`ifdef ICACHE_STATS_EN
  logic        inc_read, inc_hit, inc_miss, clr_cnt;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] read_cnt_q, read_cnt_d;

  assign inc_read = (state_q == LOOKUP);
  assign inc_hit  = inc_read && hit_any;
  assign inc_miss = inc_read && !hit_any;
  assign clr_cnt  = (state_q == IDLE) && bus.cmd_valid
                    && (bus.cmd == CMD_CLEAR);

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    read_cnt_d = read_cnt_q;
    if (clr_cnt) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      read_cnt_d = '0;
    end else begin
      if (inc_hit && hit_cnt_q != '1)
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (inc_miss && miss_cnt_q != '1)
        miss_cnt_d = miss_cnt_q + 32'd1;
      if (inc_read && read_cnt_q != '1)
        read_cnt_d = read_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      read_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      read_cnt_q <= read_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
  assign bus.read_cnt = read_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
  assign bus.read_cnt = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && state_q == IDLE && bus.cmd_valid
        && bus.cmd == CMD_PRINT) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          if (valid_mem[s][w])
            $display("icache set %0d way %0d tag %h age %0d",
                     s, w, tag_mem[s][w], age_mem[s][w]);
    end
  end
`endif
endmodule

// File: tb/tb_ins_cache_nway.sv
// Scoreboard bench for ins_cache_nway (WAYS=2, 16 sets, 64-byte lines).
// Counter expectations follow ICACHE_STATS_EN.
module tb_ins_cache_nway;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_cache_nway_if #(.ADDR_W(32), .LINE_LOG2(6)) bus ();

  ins_cache_nway #(
    .WAYS(2), .SETS_LOG2(4), .LINE_LOG2(6), .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int rsp_cnt = 0;
  bit exp_q [$];
  logic [31:0] exp_hit, exp_miss, exp_read;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: rsp_valid=1 hit=%0b, none expected",
                 bus.rsp_hit);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (bus.rsp_hit !== e)
          $display("FAIL rsp_hit: got %0b expected %0b", bus.rsp_hit, e);
        else passes++;
      end
    end
  end

  task automatic do_reset(input bit check_len);
    int n;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_hit = '0; exp_miss = '0; exp_read = '0;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (check_len) begin
      checks++;
      if (n !== 16) $display("FAIL sweep_len: ready low %0d cycles, expected 16", n);
      else passes++;
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      $display("FAIL issue_ready: ready=%0b after %0d cycles, expected 1",
               bus.ready, n);
    end
    bus.cmd = c;
    bus.addr = a;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input bit hit);
    int n, start;
    exp_q.push_back(hit);
    exp_read = sat_inc(exp_read);
    if (hit) exp_hit = sat_inc(exp_hit);
    else exp_miss = sat_inc(exp_miss);
    start = rsp_cnt;
    issue(4'd2, a);
    if (!hit) begin
      n = 0;
      while (bus.fill_req !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== 2) $display("FAIL fill_req_lat: %0d cycles, expected 2", n);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.fill_req !== 1'b1 || bus.fill_addr !== a[31:6])
        $display("FAIL fill_addr: req=%0b addr=%h expected req=1 addr=%h",
                 bus.fill_req, bus.fill_addr, a[31:6]);
      else passes++;
      bus.fill_ack = 1'b1;
      @(posedge clk);
      #1 bus.fill_ack = 1'b0;
    end
    n = 0;
    while (rsp_cnt == start && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n !== 2) $display("FAIL rsp_lat: %0d cycles for %h, expected 2", n, a);
    else passes++;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    checks++;
    if (bus.fill_req !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0 ||
        bus.read_cnt !== 32'd0)
      $display("FAIL reset_state: req=%0b rv=%0b h=%0d m=%0d r=%0d expected all 0",
               bus.fill_req, bus.rsp_valid, bus.hit_cnt, bus.miss_cnt,
               bus.read_cnt);
    else passes++;
  endtask

  task automatic test_miss_hit;
    fetch(32'h0000_1040, 1'b0);
    fetch(32'h0000_1044, 1'b1);
    checks++;
    if (bus.hit_cnt !== (STATS ? exp_hit : 32'd0) ||
        bus.miss_cnt !== (STATS ? exp_miss : 32'd0) ||
        bus.read_cnt !== (STATS ? exp_read : 32'd0))
      $display("FAIL miss_hit_cnt: h=%0d m=%0d r=%0d expected %0d %0d %0d",
               bus.hit_cnt, bus.miss_cnt, bus.read_cnt,
               STATS ? exp_hit : 0, STATS ? exp_miss : 0, STATS ? exp_read : 0);
    else passes++;
  endtask

  task automatic test_lru;
    do_reset(1'b0);
    fetch(32'h040, 1'b0);
    fetch(32'h440, 1'b0);
    fetch(32'h040, 1'b1);
    fetch(32'h840, 1'b0);
    fetch(32'h040, 1'b1);
    fetch(32'h440, 1'b0);
    checks++;
    if (bus.hit_cnt !== (STATS ? 32'd2 : 32'd0) ||
        bus.miss_cnt !== (STATS ? 32'd4 : 32'd0))
      $display("FAIL lru_cnt: h=%0d m=%0d expected %0d %0d",
               bus.hit_cnt, bus.miss_cnt, STATS ? 2 : 0, STATS ? 4 : 0);
    else passes++;
  endtask

  task automatic test_invalidate;
    do_reset(1'b0);
    fetch(32'h040, 1'b0);
    issue(4'd3, 32'h040);
    fetch(32'h040, 1'b0);
    checks++;
    if (bus.hit_cnt !== 32'd0 || bus.miss_cnt !== (STATS ? 32'd2 : 32'd0))
      $display("FAIL inv_cnt: h=%0d m=%0d expected 0 %0d",
               bus.hit_cnt, bus.miss_cnt, STATS ? 2 : 0);
    else passes++;
    issue(4'd3, 32'h440);
    fetch(32'h040, 1'b1);
  endtask

  task automatic test_other_cmds;
    issue(4'd4, 32'h040);
    checks++;
    if (bus.ready !== 1'b1) $display("FAIL other_ready: ready=%0b expected 1", bus.ready);
    else passes++;
    issue(4'd9, 32'h0);
    fetch(32'h040, 1'b1);
  endtask

  task automatic test_reset_mid_fill;
    int n;
    do_reset(1'b0);
    fetch(32'h2080, 1'b0);
    issue(4'd2, 32'h3080);
    n = 0;
    while (bus.fill_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.fill_req !== 1'b1) $display("FAIL midfill_req: fill_req=0 expected 1");
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hit = '0; exp_miss = '0; exp_read = '0;
    @(negedge clk);
    checks++;
    if (bus.fill_req !== 1'b0 || bus.fill_addr !== 26'd0 || bus.ready !== 1'b0)
      $display("FAIL midfill_rst: req=%0b addr=%h ready=%0b expected 0 0 0",
               bus.fill_req, bus.fill_addr, bus.ready);
    else passes++;
    bus.fill_ack = 1'b1;
    @(posedge clk);
    #1 bus.fill_ack = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.miss_cnt !== 32'd0 || bus.read_cnt !== 32'd0)
      $display("FAIL midfill_cnt: m=%0d r=%0d expected 0 0",
               bus.miss_cnt, bus.read_cnt);
    else passes++;
    fetch(32'h2080, 1'b0);
    fetch(32'h3080, 1'b0);
  endtask

  task automatic test_saturation;
    do_reset(1'b0);
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.miss_cnt_q;
    exp_miss = 32'hFFFF_FFFE;
`endif
    fetch(32'h3000, 1'b0);
    fetch(32'h3400, 1'b0);
    checks++;
    if (bus.miss_cnt !== (STATS ? exp_miss : 32'd0))
      $display("FAIL sat_miss: got %h expected %h", bus.miss_cnt,
               STATS ? exp_miss : 32'd0);
    else passes++;
  endtask

  initial begin
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    bus.addr = '0;
    bus.fill_ack = 1'b0;
    exp_hit = '0; exp_miss = '0; exp_read = '0;
    test_reset;
    test_miss_hit;
    test_lru;
    test_invalidate;
    test_other_cmds;
    test_reset_mid_fill;
    test_saturation;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d responses missing", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ins_cache_nway.md
INS_CACHE_NWAY -- requirements
Module: ins_cache_nway

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of 2 from 1 to 8.
REQ-002 Parameter SETS_LOG2, default 14, log2 of the set count.
REQ-003 Parameter LINE_LOG2, default 6, log2 of the line size in bytes.
REQ-004 Parameter ADDR_W, default 32, address width; TAG_W = ADDR_W-SETS_LOG2-LINE_LOG2.
REQ-005 Port clk, input, 1, the single clock; all logic SHALL be rising-edge clk.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port cmd, input, 4, command code: 8 clear, 3 invalidate, 2 fetch, 9 print.
REQ-008 Port cmd_valid, input, 1, cmd/addr valid.
REQ-009 Port addr, input, ADDR_W, command address.
REQ-010 Port ready, output, 1, block can accept a command.
REQ-011 Port fill_req, output, 1, line fill request to next level.
REQ-012 Port fill_addr, output, ADDR_W-LINE_LOG2, line address addr[ADDR_W-1:LINE_LOG2].
REQ-013 Port fill_ack, input, 1, next level completed the fill.
REQ-014 Port rsp_valid, output, 1, one-cycle fetch completion pulse.
REQ-015 Port rsp_hit, output, 1, fetch hit qualifier, valid with rsp_valid.
REQ-016 Ports hit_cnt, miss_cnt, read_cnt, output, 32, statistics counters.

Function
REQ-017 A command SHALL be accepted on a clk edge with cmd_valid=1 and ready=1; addr is captured at acceptance.
REQ-018 FSM states: SWEEP, IDLE, LOOKUP, FILL, INSTALL; ready SHALL be 1 only in IDLE.
REQ-019 Fetch: IDLE->LOOKUP; read_cnt increments by 1 in LOOKUP.
REQ-020 Hit, meaning a valid way of set addr[SETS_LOG2+LINE_LOG2-1:LINE_LOG2] holds the tag: the cycle after LOOKUP, rsp_valid=1, rsp_hit=1, hit_cnt+1, state IDLE.
REQ-021 Miss: LOOKUP->FILL, miss_cnt+1; fill_req=1 with stable fill_addr from the first FILL cycle until fill_ack is sampled 1.
REQ-022 INSTALL, one cycle after ack: write the tag, set valid, update ages; the following cycle rsp_valid=1, rsp_hit=0, state IDLE.
REQ-023 Victim selection: the lowest-index invalid way; if all ways are valid, the way with the maximum age.
REQ-024 Ages: log2(WAYS) bits per way; the accessed way is set to 0; ways younger than its old age increment by 1; ages form a permutation of 0..WAYS-1 after every SWEEP.
REQ-025 Invalidate: one cycle; clear valid on the matching valid way; ages and counters unchanged; a tag miss is a no-op.
REQ-026 Clear, cmd 8: enter SWEEP; zero all counters.
REQ-027 SWEEP: one set per cycle from set 0 to SETS-1, clearing valid and loading ages with way index; SETS cycles in total, then IDLE.
REQ-028 Print, cmd 9: one cycle; simulation-only $display of valid lines; no state change.
REQ-029 Other cmd codes: consumed in one cycle with no effect.
REQ-030 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-031 fill_ack outside FILL SHALL be ignored.
REQ-032 rsp_valid, rsp_hit, and fill_req SHALL be 0 whenever not asserted per REQ-020 to REQ-022.

Reset
REQ-033 rst=1 SHALL, on the same edge, force SWEEP from set 0 and zero the counters, rsp_valid, rsp_hit, fill_req, fill_addr, and ready, overriding any state including FILL.
REQ-034 rst held for multiple cycles SHALL restart the sweep at set 0 each cycle.

Configuration
REQ-035 Macro ICACHE_STATS_EN: when defined, the counters operate per REQ-019 to REQ-030.
REQ-036 When ICACHE_STATS_EN is undefined, the counter registers SHALL be omitted and hit_cnt, miss_cnt, and read_cnt SHALL be tied to 0; caching behaviour is identical in both cases.

Verification
REQ-037 Use WAYS=2, SETS_LOG2=4, LINE_LOG2=6 for all scenarios.
REQ-038 Reset: rst 1 cycle -> ready=0 for 16 cycles, then ready=1; counters 0.
REQ-039 Miss then hit: fetch 0x00001040 -> fill_req=1, fill_addr=0x0000041; ack -> rsp_hit=0; fetch 0x00001044 -> rsp_hit=1 one cycle after LOOKUP; hit=1, miss=1, read=2.
REQ-040 LRU eviction in set 1: fetch A=0x040, B=0x440, A, C=0x840 -> C evicts B; fetch A -> hit; fetch B -> miss.
REQ-041 Invalidate: fetch 0x040, invalidate 0x040, fetch 0x040 -> miss; counters hit=0, miss=2.
REQ-042 Reset mid-fill: rst while fill_req=1 and fill_ack withheld -> fill_req=0 next cycle; a later fill_ack pulse has no effect; counters 0.
REQ-043 Saturation: force miss_cnt to 32'hFFFFFFFE, then two misses -> miss_cnt=32'hFFFFFFFF.
